// File: rtl/core_pkg.sv
// Shared constants and state encoding for the core-local interrupt controller.
package core_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR_MEPC,
    ST_WR_MCAUSE,
    ST_WR_MSTATUS,
    ST_ASSERT,
    ST_WR_MRET
  } clint_state_e;

  localparam logic [31:0] INST_ECALL  = 32'h0000_0073;
  localparam logic [31:0] INST_EBREAK = 32'h0010_0073;
  localparam logic [31:0] INST_MRET   = 32'h3020_0073;

  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MIE     = 12'h304;
  localparam logic [11:0] CSR_MTVEC   = 12'h305;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;

  localparam logic [31:0] CAUSE_ECALL  = 32'd11;
  localparam logic [31:0] CAUSE_EBREAK = 32'd3;
  localparam int IRQ_CAUSE_BASE   = 16;
  localparam int MSTATUS_MIE_BIT  = 3;
  localparam int MSTATUS_MPIE_BIT = 7;

endpackage

// File: rtl/int_prio_enc.sv
// Fixed-priority encoder: lowest set request bit wins.
module int_prio_enc #(
  parameter int INT_NUM = 8,
  parameter int IDX_W   = 3
) (
  input  logic [INT_NUM-1:0] req_i,
  output logic               valid_o,
  output logic [IDX_W-1:0]   idx_o
);

  always_comb begin
    valid_o = |req_i;
    idx_o   = '0;
    // Scan high to low so the lowest index is the last (winning) assignment.
    for (int k = INT_NUM - 1; k >= 0; k--) begin
      if (req_i[k]) idx_o = IDX_W'(k);
    end
  end

endmodule

// File: rtl/clint_multi.sv
// Core-local interrupt controller: saves trap state through the CSR write
// port one register per cycle, then redirects to the trap vector or mepc.
module clint_multi
  import core_pkg::*;
#(
  parameter int INT_NUM    = 8,
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int CSR_ADDR_W = 12
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [INT_NUM-1:0]    int_req_i,
  input  logic [31:0]           inst_i,
  input  logic [ADDR_W-1:0]     inst_addr_i,
  input  logic                  jump_flag_i,
  input  logic [ADDR_W-1:0]     jump_addr_i,
  input  logic                  hold_flag_i,
  input  logic [DATA_W-1:0]     csr_mtvec_i,
  input  logic [DATA_W-1:0]     csr_mepc_i,
  input  logic [DATA_W-1:0]     csr_mstatus_i,
  input  logic [DATA_W-1:0]     csr_mie_i,
  output logic                  csr_wen_o,
  output logic [CSR_ADDR_W-1:0] csr_waddr_o,
  output logic [DATA_W-1:0]     csr_wdata_o,
  output logic                  clint_busy_o,
  output logic                  int_assert_o,
  output logic [ADDR_W-1:0]     int_addr_o,
  output logic [INT_NUM-1:0]    int_ack_o
);

  localparam int IDX_W = (INT_NUM > 1) ? $clog2(INT_NUM) : 1;

  clint_state_e      state_q, state_d;
  logic [DATA_W-1:0] cause_q, cause_d;
  logic [ADDR_W-1:0] ret_pc_q, ret_pc_d;
  logic [IDX_W-1:0]  idx_q, idx_d;

  logic [INT_NUM-1:0] irq_masked;
  logic               irq_vld;
  logic [IDX_W-1:0]   irq_idx;
  logic [ADDR_W-1:0]  mtvec_base;
  logic               is_sync, is_mret;
  logic [3*DATA_W-1:0] unused_csr;

  // Only some CSR bits matter here; the rest are intentionally ignored.
  assign unused_csr = {csr_mie_i, csr_mtvec_i, csr_mepc_i};

  assign irq_masked = int_req_i & csr_mie_i[IRQ_CAUSE_BASE +: INT_NUM]
                    & {INT_NUM{csr_mstatus_i[MSTATUS_MIE_BIT]}};
  assign is_sync    = (inst_i == INST_ECALL) || (inst_i == INST_EBREAK);
  assign is_mret    = (inst_i == INST_MRET);
  assign mtvec_base = {csr_mtvec_i[ADDR_W-1:2], 2'b00};

  int_prio_enc #(.INT_NUM(INT_NUM), .IDX_W(IDX_W)) u_prio (
    .req_i   (irq_masked),
    .valid_o (irq_vld),
    .idx_o   (irq_idx)
  );

  always_comb begin
    state_d      = state_q;
    cause_d      = cause_q;
    ret_pc_d     = ret_pc_q;
    idx_d        = idx_q;
    csr_wen_o    = 1'b0;
    csr_waddr_o  = '0;
    csr_wdata_o  = '0;
    clint_busy_o = 1'b0;
    int_assert_o = 1'b0;
    int_addr_o   = '0;
    int_ack_o    = '0;
    case (state_q)
      ST_IDLE: begin
        // Reset gating keeps busy low while rst_i is asserted.
        if (!rst_i && !hold_flag_i) begin
          if (is_sync) begin
            clint_busy_o = 1'b1;
            cause_d  = (inst_i == INST_ECALL) ? DATA_W'(CAUSE_ECALL) : DATA_W'(CAUSE_EBREAK);
            idx_d    = '0;
            ret_pc_d = inst_addr_i;
            state_d  = ST_WR_MEPC;
          end else if (is_mret) begin
            clint_busy_o = 1'b1;
            state_d      = ST_WR_MRET;
          end else if (irq_vld) begin
            clint_busy_o = 1'b1;
            cause_d  = DATA_W'(IRQ_CAUSE_BASE) + DATA_W'(irq_idx);
            cause_d[DATA_W-1] = 1'b1;
            idx_d    = irq_idx;
            ret_pc_d = jump_flag_i ? jump_addr_i : inst_addr_i;
            state_d  = ST_WR_MEPC;
          end
        end
      end
      ST_WR_MEPC: begin
        clint_busy_o = 1'b1;
        csr_wen_o    = 1'b1;
        csr_waddr_o  = CSR_ADDR_W'(CSR_MEPC);
        csr_wdata_o  = DATA_W'(ret_pc_q);
        state_d      = ST_WR_MCAUSE;
      end
      ST_WR_MCAUSE: begin
        clint_busy_o = 1'b1;
        csr_wen_o    = 1'b1;
        csr_waddr_o  = CSR_ADDR_W'(CSR_MCAUSE);
        csr_wdata_o  = cause_q;
        state_d      = ST_WR_MSTATUS;
      end
      ST_WR_MSTATUS: begin
        clint_busy_o = 1'b1;
        csr_wen_o    = 1'b1;
        csr_waddr_o  = CSR_ADDR_W'(CSR_MSTATUS);
        csr_wdata_o  = csr_mstatus_i;
        csr_wdata_o[MSTATUS_MPIE_BIT] = csr_mstatus_i[MSTATUS_MIE_BIT];
        csr_wdata_o[MSTATUS_MIE_BIT]  = 1'b0;
        state_d      = ST_ASSERT;
      end
      ST_ASSERT: begin
        clint_busy_o = 1'b1;
        int_assert_o = 1'b1;
        // Vectored mode applies to interrupts only; exceptions use the base.
        if (csr_mtvec_i[1:0] == 2'b01 && cause_q[DATA_W-1])
          int_addr_o = mtvec_base + ADDR_W'({cause_q[4:0], 2'b00});
        else
          int_addr_o = mtvec_base;
        if (cause_q[DATA_W-1]) int_ack_o = INT_NUM'(1) << idx_q;
        state_d      = ST_IDLE;
      end
      ST_WR_MRET: begin
        clint_busy_o = 1'b1;
        csr_wen_o    = 1'b1;
        csr_waddr_o  = CSR_ADDR_W'(CSR_MSTATUS);
        csr_wdata_o  = csr_mstatus_i;
        csr_wdata_o[MSTATUS_MIE_BIT]  = csr_mstatus_i[MSTATUS_MPIE_BIT];
        csr_wdata_o[MSTATUS_MPIE_BIT] = 1'b1;
        int_assert_o = 1'b1;
        int_addr_o   = csr_mepc_i[ADDR_W-1:0];
        state_d      = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= ST_IDLE;
      cause_q  <= '0;
      ret_pc_q <= '0;
      idx_q    <= '0;
    end else begin
      state_q  <= state_d;
      cause_q  <= cause_d;
      ret_pc_q <= ret_pc_d;
      idx_q    <= idx_d;
    end
  end

endmodule

// File: tb/tb_clint_multi.sv
// Directed bench for clint_multi: trap entry, vectoring, priority, mret, reset abort.
module tb_clint_multi;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  int_req;
  logic [31:0] inst, inst_addr, jump_addr, mtvec, mepc, mstatus, mie;
  logic        jump_flag, hold_flag;
  logic        csr_wen, busy, int_assert;
  logic [11:0] csr_waddr;
  logic [31:0] csr_wdata, int_addr;
  logic [7:0]  int_ack;

  int checks = 0;
  int failures = 0;
  logic [63:0] got, exp;

  always #5 clk = ~clk;

  clint_multi #(.INT_NUM(8), .ADDR_W(32), .DATA_W(32), .CSR_ADDR_W(12)) dut (
    .clk_i(clk), .rst_i(rst), .int_req_i(int_req), .inst_i(inst),
    .inst_addr_i(inst_addr), .jump_flag_i(jump_flag), .jump_addr_i(jump_addr),
    .hold_flag_i(hold_flag), .csr_mtvec_i(mtvec), .csr_mepc_i(mepc),
    .csr_mstatus_i(mstatus), .csr_mie_i(mie), .csr_wen_o(csr_wen),
    .csr_waddr_o(csr_waddr), .csr_wdata_o(csr_wdata), .clint_busy_o(busy),
    .int_assert_o(int_assert), .int_addr_o(int_addr), .int_ack_o(int_ack)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1; int_req = 8'h0C; inst = 32'h13; inst_addr = '0; jump_flag = 1'b0;
    jump_addr = '0; hold_flag = 1'b0; mtvec = 32'h100; mepc = '0; mstatus = 32'h8;
    mie = 32'h000C0000;
    #12;
    got = {csr_wen, csr_waddr, busy, int_assert, int_ack, 32'h0};
    exp = 64'h0;
    checks++; if (got !== exp || csr_wdata !== 32'h0 || int_addr !== 32'h0) begin
      failures++; $display("FAIL reset_outputs got=%h exp=%h", got, exp); end
    int_req = 8'h00;
    @(negedge clk); rst = 1'b0;
    tick;
  endtask

  task automatic test_async_direct;
    int_req = 8'h0C; mie = 32'h000C0000; mstatus = 32'h8; mtvec = 32'h100; inst_addr = 32'h2000;
    #1;
    checks++; if (busy !== 1'b1 || csr_wen !== 1'b0) begin
      failures++; $display("FAIL async_detect_busy got=%b%b exp=10", busy, csr_wen); end
    tick;
    int_req = 8'h00; // source drops mid-sequence; ack must still go to channel 2
    got = {19'h0, csr_wen, csr_waddr, csr_wdata}; exp = {19'h0, 1'b1, 12'h341, 32'h2000};
    checks++; if (got !== exp) begin failures++; $display("FAIL async_mepc got=%h exp=%h", got, exp); end
    tick;
    got = {19'h0, csr_wen, csr_waddr, csr_wdata}; exp = {19'h0, 1'b1, 12'h342, 32'h80000012};
    checks++; if (got !== exp) begin failures++; $display("FAIL async_mcause got=%h exp=%h", got, exp); end
    tick;
    got = {19'h0, csr_wen, csr_waddr, csr_wdata}; exp = {19'h0, 1'b1, 12'h300, 32'h80};
    checks++; if (got !== exp) begin failures++; $display("FAIL async_mstatus got=%h exp=%h", got, exp); end
    tick;
    got = {21'h0, busy, int_assert, csr_wen, int_ack, int_addr}; exp = {21'h0, 3'b110, 8'h04, 32'h100};
    checks++; if (got !== exp) begin failures++; $display("FAIL async_assert got=%h exp=%h", got, exp); end
    tick;
    checks++; if ({busy, int_assert, csr_wen} !== 3'b000) begin
      failures++; $display("FAIL async_back_idle got=%b exp=000", {busy, int_assert, csr_wen}); end
  endtask

  task automatic test_async_vectored;
    int_req = 8'h0C; mie = 32'h000C0000; mstatus = 32'h8; mtvec = 32'h101; inst_addr = 32'h2000;
    tick; int_req = 8'h00;
    tick;
    checks++; if (csr_wdata !== 32'h80000012) begin
      failures++; $display("FAIL vec_mcause got=%h exp=80000012", csr_wdata); end
    tick; tick;
    got = {31'h0, int_assert, int_addr}; exp = {31'h0, 1'b1, 32'h148};
    checks++; if (got !== exp) begin failures++; $display("FAIL vec_addr got=%h exp=%h", got, exp); end
    tick;
  endtask

  task automatic test_ecall_priority;
    inst = 32'h00000073; inst_addr = 32'h3000; int_req = 8'h01; mie = 32'h00010000;
    mstatus = 32'h8; mtvec = 32'h101;
    #1;
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL ecall_busy got=%b exp=1", busy); end
    tick; inst = 32'h13; int_req = 8'h00;
    got = {19'h0, csr_wen, csr_waddr, csr_wdata}; exp = {19'h0, 1'b1, 12'h341, 32'h3000};
    checks++; if (got !== exp) begin failures++; $display("FAIL ecall_mepc got=%h exp=%h", got, exp); end
    tick;
    got = {19'h0, csr_wen, csr_waddr, csr_wdata}; exp = {19'h0, 1'b1, 12'h342, 32'h0000000B};
    checks++; if (got !== exp) begin failures++; $display("FAIL ecall_mcause got=%h exp=%h", got, exp); end
    tick; tick;
    got = {23'h0, int_assert, int_ack, int_addr}; exp = {23'h0, 1'b1, 8'h00, 32'h100};
    checks++; if (got !== exp) begin failures++; $display("FAIL ecall_assert got=%h exp=%h", got, exp); end
    tick;
  endtask

  task automatic test_jump_mepc;
    int_req = 8'h01; mie = 32'h00010000; mstatus = 32'h8; mtvec = 32'h100;
    inst_addr = 32'h2000; jump_flag = 1'b1; jump_addr = 32'h4000;
    tick; jump_flag = 1'b0; int_req = 8'h00;
    checks++; if (csr_wdata !== 32'h4000) begin
      failures++; $display("FAIL jump_mepc got=%h exp=00004000", csr_wdata); end
    tick;
    checks++; if (csr_wdata !== 32'h80000010) begin
      failures++; $display("FAIL jump_mcause got=%h exp=80000010", csr_wdata); end
    tick; tick;
    got = {23'h0, int_assert, int_ack, int_addr}; exp = {23'h0, 1'b1, 8'h01, 32'h100};
    checks++; if (got !== exp) begin failures++; $display("FAIL jump_assert got=%h exp=%h", got, exp); end
    tick;
  endtask

  task automatic test_mret;
    inst = 32'h30200073; mstatus = 32'h80; mepc = 32'h2004; int_req = 8'h00;
    #1;
    checks++; if (busy !== 1'b1 || int_assert !== 1'b0) begin
      failures++; $display("FAIL mret_detect got=%b%b exp=10", busy, int_assert); end
    tick; inst = 32'h13;
    got = {csr_wen, csr_waddr, csr_wdata, int_assert, 18'h0}; exp = {1'b1, 12'h300, 32'h88, 1'b1, 18'h0};
    checks++; if (got !== exp || int_addr !== 32'h2004) begin
      failures++; $display("FAIL mret_write got=%h/%h exp=%h/00002004", got, int_addr, exp); end
    tick;
    checks++; if ({int_assert, csr_wen, busy} !== 3'b000) begin
      failures++; $display("FAIL mret_back_idle got=%b exp=000", {int_assert, csr_wen, busy}); end
  endtask

  task automatic test_reset_mid_sequence;
    int seen;
    int_req = 8'h0C; mie = 32'h000C0000; mstatus = 32'h8; mtvec = 32'h100; inst_addr = 32'h2000;
    tick; tick;
    checks++; if (csr_waddr !== 12'h342) begin
      failures++; $display("FAIL midrst_in_mcause got=%h exp=342", csr_waddr); end
    rst = 1'b1; #1;
    got = {csr_wen, csr_waddr, busy, int_assert, int_ack, 32'h0};
    checks++; if (got !== 64'h0 || csr_wdata !== 32'h0 || int_addr !== 32'h0) begin
      failures++; $display("FAIL midrst_outputs got=%h exp=0", got); end
    int_req = 8'h00;
    @(negedge clk); rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 5; i++) begin
      tick;
      if (csr_wen || int_assert || busy) seen++;
    end
    checks++; if (seen !== 0) begin failures++; $display("FAIL midrst_no_resume got=%0d exp=0", seen); end
  endtask

  task automatic test_no_trap;
    int_req = 8'h0C; mie = 32'h000C0000; mstatus = 32'h0;
    #1;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL mie_off_busy got=%b exp=0", busy); end
    tick;
    checks++; if (csr_wen !== 1'b0) begin failures++; $display("FAIL mie_off_wen got=%b exp=0", csr_wen); end
    mstatus = 32'h8; hold_flag = 1'b1; inst = 32'h00000073;
    #1;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL hold_busy got=%b exp=0", busy); end
    tick;
    checks++; if (csr_wen !== 1'b0) begin failures++; $display("FAIL hold_wen got=%b exp=0", csr_wen); end
    int_req = 8'h00; inst = 32'h13; hold_flag = 1'b0;
    tick;
  endtask

  initial begin
    test_reset;
    test_async_direct;
    test_async_vectored;
    test_ecall_priority;
    test_jump_mepc;
    test_mret;
    test_reset_mid_sequence;
    test_no_trap;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/clint_multi.md
Name: clint_multi

Overview:
Parametrised core-local interrupt controller. It handles INT_NUM maskable external interrupt sources with fixed priority, plus the ecall, ebreak and mret instructions seen in decode. A sequential FSM saves trap state through the CSR write port and holds the pipeline while it does so. It then issues a one-cycle redirect to the trap vector (direct or vectored mode) or to mepc.

Parameters:
INT_NUM, 8, number of external interrupt channels (1..16)
ADDR_W, 32, instruction address width
DATA_W, 32, CSR data width
CSR_ADDR_W, 12, CSR address width

Ports:
clk_i  in  1  core clock
rst_i  in  1  asynchronous, active-high reset
int_req_i  in  INT_NUM  level interrupt requests
inst_i  in  32  instruction currently in ID
inst_addr_i  in  ADDR_W  PC of inst_i
jump_flag_i  in  1  EX is redirecting this cycle
jump_addr_i  in  ADDR_W  EX redirect target
hold_flag_i  in  1  pipeline stalled by another source
csr_mtvec_i  in  DATA_W  mtvec value
csr_mepc_i  in  DATA_W  mepc value
csr_mstatus_i  in  DATA_W  mstatus value
csr_mie_i  in  DATA_W  mie value; bits [16+INT_NUM-1:16] enable the channels
csr_wen_o  out  1  CSR write enable
csr_waddr_o  out  CSR_ADDR_W  CSR write address
csr_wdata_o  out  DATA_W  CSR write data
clint_busy_o  out  1  hold request to ctrl
int_assert_o  out  1  redirect pulse
int_addr_o  out  ADDR_W  redirect target
int_ack_o  out  INT_NUM  one-hot acknowledge of the serviced channel

Behaviour:
- One clock domain. Reset is asynchronous and active-high on rst_i.
- Reset values:
  - All outputs 0.
  - State IDLE.
  - Latched cause, latched return PC and latched channel index all 0.
- States: IDLE, WR_MEPC, WR_MCAUSE, WR_MSTATUS, ASSERT, WR_MRET.
- Decode (IDLE only; ignored while hold_flag_i=1):
  - ecall = 32'h00000073, cause 11.
  - ebreak = 32'h00100073, cause 3.
  - mret = 32'h30200073.
- Async eligibility:
  - A channel is eligible when int_req_i[k], mie[16+k] and mstatus.MIE (bit 3) are all set.
  - The winner is the lowest eligible index (priority encoder).
  - Async cause = 32'h80000000 | (16+k).
- Priority in IDLE: synchronous trap, then mret, then async interrupt.
- Trap entry, detect cycle:
  - clint_busy_o=1 combinationally.
  - Latch cause and channel index.
  - Return PC latch: sync trap → inst_addr_i; async → jump_addr_i if jump_flag_i, else inst_addr_i.
- Trap entry sequence, one CSR write per cycle, clint_busy_o=1 throughout:
  - WR_MEPC: addr 12'h341, data = return PC.
  - WR_MCAUSE: addr 12'h342, data = cause.
  - WR_MSTATUS: addr 12'h300, data = mstatus with MPIE(bit 7) ← MIE and MIE ← 0.
  - ASSERT: int_assert_o=1 for exactly one cycle.
    - int_addr_o: if mtvec[1:0]==2'b01 and the cause is async → {mtvec[ADDR_W-1:2],2'b00} + 4*cause[4:0]; otherwise → {mtvec[ADDR_W-1:2],2'b00}.
    - int_ack_o one-hot for async, 0 for sync.
    - Then → IDLE.
- mret sequence:
  - Detect cycle: busy=1, → WR_MRET.
  - WR_MRET: write 12'h300 with MIE ← MPIE and MPIE ← 1. int_assert_o=1, int_addr_o=csr_mepc_i. Then → IDLE.
- Latency: async detect to redirect = 4 cycles; mret detect to redirect = 1 cycle.
- csr_wen_o is high only in WR_* states. Address and data are 0 otherwise.
- A request dropping mid-sequence does not abort it. The latched index is still acked.
- No nesting: MIE=0 after entry blocks further async traps until mret.
- Reset mid-sequence returns to IDLE immediately. No partial CSR write or redirect is issued afterwards.
- int_req_i held high after ack with MIE=1 re-traps; clearing the source is software's job.
- hold_flag_i=1 while in a non-IDLE state has no effect: the sequence continues.

Decomposition:
- core_pkg holds:
  - the state enum;
  - INST_ECALL, INST_EBREAK, INST_MRET;
  - CSR_MSTATUS / MIE / MTVEC / MEPC / MCAUSE addresses;
  - CAUSE_ECALL, CAUSE_EBREAK, IRQ_CAUSE_BASE = 16;
  - MSTATUS_MIE_BIT = 3, MSTATUS_MPIE_BIT = 7.
- Sub-module int_prio_enc (parametrised by INT_NUM) takes the masked request vector and returns a valid bit and the index.

Test Plan:
- int_req_i=8'h0C, mie=32'h000C0000, mstatus=32'h8, mtvec=32'h100, inst_addr=32'h2000 → 12'h341←2000, 12'h342←80000012, 12'h300←80, int_addr_o=100, int_ack_o=8'h04, 4 cycles.
- Same as above with mtvec=32'h101 → int_addr_o=32'h148.
- inst_i=32'h00000073 at 32'h3000 with int_req_i=8'h01 enabled in the same cycle → ecall wins, mcause=11, mepc=3000, int_ack_o=0.
- Async trap with jump_flag_i=1, jump_addr_i=32'h4000 → mepc=4000.
- inst_i=32'h30200073, mstatus=32'h80, mepc=32'h2004 → next cycle 12'h300←88, int_assert_o=1, int_addr_o=2004.
- rst_i pulsed during WR_MCAUSE → outputs 0 at once, no later WR_MSTATUS or ASSERT; mstatus.MIE=0 or hold_flag_i=1 with a request → no trap.
